// File: rtl/pc_unit.sv
// Program counter with branch/jump/call/return sequencing and an optional
// return-address stack (RAS).
// Optional feature macro: PC_UNIT_RAS_EN. When it is defined, a circular
// return-address stack backs call/ret. When it is undefined, call_en acts
// as a plain jump, ret_en is ignored and the stack flags are tied off.
// Reset is synchronous and active-low.
module pc_unit #(
    parameter int ADDR_W    = 4,
    parameter int RESET_VEC = 0,
    parameter int INC       = 1,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_tgt,
    input  logic              jump_en,
    input  logic              call_en,
    input  logic [ADDR_W-1:0] jump_tgt,
    input  logic              ret_en,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_next,
    output logic              ras_full,
    output logic              ras_empty,
    output logic              ras_err
);

    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(INC);

    // Sequential successor; wraps modulo 2^ADDR_W by construction.
    logic [ADDR_W-1:0] pc_inc;
    assign pc_inc = pc + STEP;

`ifdef PC_UNIT_RAS_EN

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST     = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

    // Ring buffer: top points at the newest entry. When the ring is full the
    // slot after top holds the oldest entry, so an overflowing push simply
    // writes there and the ring stays full.
    logic [ADDR_W-1:0] stack [RAS_DEPTH];
    logic [PTR_W-1:0]  top;
    logic [PTR_W-1:0]  top_up;
    logic [PTR_W-1:0]  top_dn;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              do_push;
    logic              do_pop;
    logic              overflow;
    logic              underflow;

    assign top_up = (top == LAST) ? '0 : top + PTR_W'(1);
    assign top_dn = (top == '0) ? LAST : top - PTR_W'(1);

    // Next-PC priority select and stack operation decode.
    always_comb begin
        pc_next   = pc_inc;
        do_push   = 1'b0;
        do_pop    = 1'b0;
        overflow  = 1'b0;
        underflow = 1'b0;
        if (stall) begin
            pc_next = pc;
        end else if (ret_en) begin
            if (cnt != '0) begin
                pc_next = stack[top];
                do_pop  = 1'b1;
            end else begin
                underflow = 1'b1;
            end
        end else if (call_en) begin
            pc_next  = jump_tgt;
            do_push  = 1'b1;
            overflow = (cnt == FULL_CNT);
        end else if (jump_en) begin
            pc_next = jump_tgt;
        end else if (branch_en) begin
            pc_next = branch_tgt;
        end
    end

    // Occupancy update; an overflowing push leaves the count saturated.
    always_comb begin
        cnt_nxt = cnt;
        if (do_pop) begin
            cnt_nxt = cnt - CNT_W'(1);
        end else if (do_push && !overflow) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    // Stack storage needs no reset: entries are only visible through cnt.
    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            stack[top_up] <= pc_inc;
        end
    end

    // PC, stack pointer, occupancy and registered flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc        <= RST_PC;
            top       <= LAST;
            cnt       <= '0;
            ras_empty <= 1'b1;
            ras_full  <= 1'b0;
            ras_err   <= 1'b0;
        end else begin
            pc  <= pc_next;
            cnt <= cnt_nxt;
            if (do_push) begin
                top <= top_up;
            end else if (do_pop) begin
                top <= top_dn;
            end
            ras_empty <= (cnt_nxt == '0);
            ras_full  <= (cnt_nxt == FULL_CNT);
            ras_err   <= overflow | underflow;
        end
    end

`else

    // Without a stack, ret_en has no effect on the datapath.
    logic unused_ret;
    assign unused_ret = ret_en;

    // Next-PC priority select; call degenerates to a jump.
    always_comb begin
        pc_next = pc_inc;
        if (stall) begin
            pc_next = pc;
        end else if (call_en || jump_en) begin
            pc_next = jump_tgt;
        end else if (branch_en) begin
            pc_next = branch_tgt;
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RST_PC;
        end else begin
            pc <= pc_next;
        end
    end

    assign ras_full  = 1'b0;
    assign ras_empty = 1'b1;
    assign ras_err   = 1'b0;

`endif

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit (ADDR_W=4, RESET_VEC=0, INC=1, RAS_DEPTH=4).
// The driver pushes hand-computed expectations tagged with the cycle they
// become visible; the monitor pops and compares them on the falling edge.
module tb_pc_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       stall;
    logic       branch_en;
    logic [3:0] branch_tgt;
    logic       jump_en;
    logic       call_en;
    logic [3:0] jump_tgt;
    logic       ret_en;
    logic [3:0] pc;
    logic [3:0] pc_next;
    logic       ras_full;
    logic       ras_empty;
    logic       ras_err;

    pc_unit #(
        .ADDR_W(4), .RESET_VEC(0), .INC(1), .RAS_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .branch_en(branch_en), .branch_tgt(branch_tgt),
        .jump_en(jump_en), .call_en(call_en), .jump_tgt(jump_tgt),
        .ret_en(ret_en), .pc(pc), .pc_next(pc_next),
        .ras_full(ras_full), .ras_empty(ras_empty), .ras_err(ras_err)
    );

    always #5 clk = ~clk;

    localparam int K_PC  = 0;
    localparam int K_NXT = 1;
    localparam int K_FLG = 2;

    typedef struct {
        int         due;
        int         kind;
        logic [3:0] exp;
        string      name;
    } item_t;

    item_t sb[$];
    int    cyc    = 0;
    int    checks = 0;
    int    errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation that has come due.
    always @(negedge clk) begin
        item_t      it;
        logic [3:0] act;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            it = sb.pop_front();
            case (it.kind)
                K_PC:    act = pc;
                K_NXT:   act = pc_next;
                default: act = {1'b0, ras_empty, ras_full, ras_err};
            endcase
            checks++;
            if (it.due != cyc || act !== it.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h (cycle %0d due %0d)",
                         it.name, act, it.exp, cyc, it.due);
            end
        end
    end

    task automatic push(input int due, input int kind, input logic [3:0] exp,
                        input string nm);
        item_t it;
        it.due = due; it.kind = kind; it.exp = exp; it.name = nm;
        sb.push_back(it);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of stimulus; ep is pc after the edge, ef = {empty,full,err}.
    task automatic step(input logic st, input logic br, input logic [3:0] bt,
                        input logic jp, input logic cl, input logic [3:0] jt,
                        input logic rt, input logic [3:0] ep, input bit cf,
                        input logic [2:0] ef, input string nm);
        rst_n = 1'b1; stall = st; branch_en = br; branch_tgt = bt;
        jump_en = jp; call_en = cl; jump_tgt = jt; ret_en = rt;
        push(cyc, K_NXT, ep, {nm, "_nxt"});
        push(cyc + 1, K_PC, ep, {nm, "_pc"});
        if (cf) push(cyc + 1, K_FLG, {1'b0, ef}, {nm, "_flags"});
        tick();
    endtask

    // Reset with stall and other controls active; they must not matter.
    task automatic do_reset(input string nm);
        rst_n = 1'b0; stall = 1'b1; jump_en = 1'b1; call_en = 1'b1;
        ret_en = 1'b1; jump_tgt = 4'h9;
        push(cyc + 1, K_PC, 4'h0, {nm, "_pc"});
        push(cyc + 1, K_FLG, 4'b0100, {nm, "_flags"});
        tick();
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; branch_en = 1'b0; branch_tgt = '0;
        jump_en = 1'b0; call_en = 1'b0; jump_tgt = '0; ret_en = 1'b0;
        tick();
        tick();
        do_reset("reset_stall");
        //   st br bt    jp cl jt    rt exp   cf flags
        step(0, 0, 4'h0, 0, 0, 4'h0, 0, 4'h1, 1, 3'b100, "first_adv");
        step(0, 0, 4'h0, 1, 0, 4'hE, 0, 4'hE, 0, 3'b000, "jump_E");
        step(0, 0, 4'h0, 0, 0, 4'h0, 0, 4'hF, 0, 3'b000, "wrap_F");
        step(0, 0, 4'h0, 0, 0, 4'h0, 0, 4'h0, 0, 3'b000, "wrap_0");
        step(0, 0, 4'h0, 0, 0, 4'h0, 0, 4'h1, 0, 3'b000, "wrap_1");
        step(0, 1, 4'h5, 1, 0, 4'h7, 0, 4'h7, 0, 3'b000, "jump_over_branch");
        step(1, 0, 4'h0, 1, 0, 4'h3, 0, 4'h7, 1, 3'b100, "stall_hold");
        step(0, 1, 4'h5, 0, 0, 4'h0, 0, 4'h5, 0, 3'b000, "branch");
        step(0, 0, 4'h0, 1, 0, 4'h3, 0, 4'h3, 0, 3'b000, "jump_3");
`ifdef PC_UNIT_RAS_EN
        step(0, 0, 4'h0, 0, 1, 4'h9, 0, 4'h9, 1, 3'b000, "call_9");
        step(0, 0, 4'h0, 0, 0, 4'h0, 0, 4'hA, 0, 3'b000, "after_call_A");
        step(0, 0, 4'h0, 0, 0, 4'h0, 0, 4'hB, 0, 3'b000, "after_call_B");
        step(0, 0, 4'h0, 0, 0, 4'h0, 1, 4'h4, 1, 3'b100, "ret_4");
        step(0, 0, 4'h0, 0, 1, 4'h8, 0, 4'h8, 1, 3'b000, "fill_1");
        step(0, 0, 4'h0, 0, 1, 4'hA, 0, 4'hA, 1, 3'b000, "fill_2");
        step(0, 0, 4'h0, 0, 1, 4'hC, 0, 4'hC, 1, 3'b000, "fill_3");
        step(0, 0, 4'h0, 0, 1, 4'hE, 0, 4'hE, 1, 3'b010, "fill_4");
        step(0, 0, 4'h0, 0, 1, 4'h1, 0, 4'h1, 1, 3'b011, "overflow");
        step(1, 0, 4'h0, 0, 1, 4'h6, 1, 4'h1, 1, 3'b010, "stall_full");
        step(0, 0, 4'h0, 0, 0, 4'h0, 1, 4'hF, 1, 3'b000, "ret_F");
        step(0, 0, 4'h0, 0, 0, 4'h0, 1, 4'hD, 1, 3'b000, "ret_D");
        step(0, 0, 4'h0, 0, 0, 4'h0, 1, 4'hB, 1, 3'b000, "ret_B");
        step(0, 0, 4'h0, 0, 0, 4'h0, 1, 4'h9, 1, 3'b100, "ret_9");
        step(0, 0, 4'h0, 0, 0, 4'h0, 1, 4'hA, 1, 3'b101, "underflow");
        step(0, 0, 4'h0, 0, 1, 4'h5, 0, 4'h5, 1, 3'b000, "call_5");
        step(0, 0, 4'h0, 0, 1, 4'h2, 1, 4'hB, 1, 3'b100, "ret_over_call");
        step(0, 0, 4'h0, 1, 0, 4'hF, 0, 4'hF, 0, 3'b000, "jump_F");
        step(0, 0, 4'h0, 0, 1, 4'h3, 0, 4'h3, 1, 3'b000, "call_wrap");
        step(0, 0, 4'h0, 0, 0, 4'h0, 1, 4'h0, 1, 3'b100, "ret_wrap");
        step(0, 0, 4'h0, 0, 1, 4'h1, 0, 4'h1, 0, 3'b000, "rf_1");
        step(0, 0, 4'h0, 0, 1, 4'h2, 0, 4'h2, 0, 3'b000, "rf_2");
        step(0, 0, 4'h0, 0, 1, 4'h3, 0, 4'h3, 0, 3'b000, "rf_3");
        step(0, 0, 4'h0, 0, 1, 4'h4, 0, 4'h4, 1, 3'b010, "rf_4");
        step(0, 0, 4'h0, 0, 1, 4'h5, 0, 4'h5, 1, 3'b011, "rf_ovf");
        do_reset("reset_after_ovf");
        step(0, 0, 4'h0, 0, 0, 4'h0, 1, 4'h1, 1, 3'b101, "post_rst_underflow");
        step(0, 0, 4'h0, 0, 0, 4'h0, 0, 4'h2, 1, 3'b100, "post_rst_adv");
`else
        step(0, 0, 4'h0, 0, 1, 4'h6, 0, 4'h6, 1, 3'b100, "call_as_jump");
        step(0, 0, 4'h0, 0, 0, 4'h0, 1, 4'h7, 1, 3'b100, "ret_ignored");
        step(0, 0, 4'h0, 0, 1, 4'h2, 1, 4'h2, 1, 3'b100, "ret_call_jump");
`endif
        step(0, 0, 4'h0, 1, 0, 4'h9, 0, 4'h9, 0, 3'b000, "jump_9");
        do_reset("reset_mid");
        step(0, 0, 4'h0, 0, 0, 4'h0, 0, 4'h1, 1, 3'b100, "post_rst_first");
        rst_n = 1'b1; stall = 1'b0; jump_en = 1'b0; call_en = 1'b0;
        ret_en = 1'b0; branch_en = 1'b0;
        for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 4, meaning the PC and target width in bits.
REQ-002 The module SHALL have parameter RESET_VEC, default 0, meaning the PC value loaded on reset.
REQ-003 The module SHALL have parameter INC, default 1, meaning the sequential increment per advance.
REQ-004 The module SHALL have parameter RAS_DEPTH, default 4, meaning the number of return-address stack entries (at least 2).
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-006 The module SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 The module SHALL have port stall, input, 1 bit: hold the PC and RAS this cycle.
REQ-008 The module SHALL have port branch_en, input, 1 bit: take the conditional branch to branch_tgt.
REQ-009 The module SHALL have port branch_tgt, input, ADDR_W bits: the branch target address.
REQ-010 The module SHALL have port jump_en, input, 1 bit: take the unconditional jump to jump_tgt.
REQ-011 The module SHALL have port call_en, input, 1 bit: call, meaning jump to jump_tgt and push the return address.
REQ-012 The module SHALL have port jump_tgt, input, ADDR_W bits: the jump/call target address.
REQ-013 The module SHALL have port ret_en, input, 1 bit: return to the top-of-stack address.
REQ-014 The module SHALL have port pc, output, ADDR_W bits: the current instruction address (registered).
REQ-015 The module SHALL have port pc_next, output, ADDR_W bits: the combinational value pc takes at the next edge, ignoring reset.
REQ-016 The module SHALL have ports ras_full and ras_empty, outputs, 1 bit each: the stack occupancy flags (registered).
REQ-017 The module SHALL have port ras_err, output, 1 bit: a one-cycle registered pulse on stack overflow or underflow.

Function
REQ-018 Per edge with rst_n high, the next PC SHALL be chosen by priority: stall (pc held), then ret_en, then call_en, then jump_en, then branch_en, then pc+INC.
REQ-019 All address arithmetic SHALL be modulo 2^ADDR_W, so pc+INC wraps from the maximum address to the low addresses without a flag.
REQ-020 While stall is high, pc, the RAS contents, its pointer and its flags SHALL be unchanged, ras_err SHALL be 0, and all other controls SHALL be ignored.
REQ-021 On a call, pc SHALL become jump_tgt and pc+INC (the wrapped value) SHALL be pushed in the same edge; latency is one cycle.
REQ-022 On a ret with RAS not empty, pc SHALL become the top entry and the entry SHALL be popped in the same edge.
REQ-023 On a ret with RAS empty (underflow), pc SHALL become pc+INC, the stack SHALL be unchanged, and ras_err SHALL be 1 for the next cycle.
REQ-024 On a call with RAS full (overflow), the push SHALL overwrite the oldest entry, occupancy SHALL stay RAS_DEPTH, ras_full SHALL stay 1, and ras_err SHALL be 1 for the next cycle.
REQ-025 When ret_en and call_en are both high, ret SHALL win; no push occurs and call_en is ignored.
REQ-026 ras_empty SHALL be 1 exactly when occupancy is 0, and ras_full SHALL be 1 exactly when occupancy equals RAS_DEPTH.
REQ-027 pc_next SHALL equal the priority result of REQ-018 computed from the current inputs and state.

Reset
REQ-028 When rst_n is low at a rising clk edge, the module SHALL set pc=RESET_VEC, RAS occupancy 0, ras_empty=1, ras_full=0 and ras_err=0, regardless of stall or any other input.
REQ-029 A reset asserted mid-sequence, including during stall or after a pending overflow, SHALL discard all stack contents, and the first post-reset advance SHALL yield RESET_VEC+INC.

Configuration
REQ-030 When macro PC_UNIT_RAS_EN is defined, the RAS and REQ-021 through REQ-026 SHALL be implemented.
REQ-031 When PC_UNIT_RAS_EN is undefined, no stack storage SHALL exist, call_en SHALL behave as jump_en, ret_en SHALL be ignored, and ras_full, ras_empty and ras_err SHALL be tied to 0, 1 and 0; all ports remain present.

Verification
REQ-032 The bench SHALL drive ADDR_W=4, INC=1, pc=4'hE with no controls for 3 cycles and observe pc = F, 0, 1 (wrap).
REQ-033 The bench SHALL hold rst_n=0 for 1 cycle with stall=1 and observe pc=RESET_VEC and ras_empty=1 on the next cycle.
REQ-034 The bench SHALL, from pc=3, drive call_en with jump_tgt=9, then wait 2 cycles, then drive ret_en, and observe pc = 9, A, B, then 4, with ras_empty=1 after the ret.
REQ-035 The bench SHALL drive branch_en with target 5 and jump_en with target 7 in the same cycle and observe pc=7; it SHALL then hold stall=1 with jump_en and observe pc remain 7.
REQ-036 The bench SHALL, with RAS_DEPTH=4, issue 5 calls and observe ras_err=1 after the 5th and ras_full=1; it SHALL then issue 5 rets and observe the first 4 return the last 4 pushed addresses and the 5th pulse ras_err with pc=pc+1.
REQ-037 The bench SHALL, with PC_UNIT_RAS_EN undefined, drive call_en with target 6 followed by ret_en and observe pc = 6 then 7, with ras_err=0 throughout.
